// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Write-side loader for the instruction memory. Accepts a framed
//            byte stream over a valid/ready handshake, packs the bytes
//            little-endian into WIDTH-bit words and writes them to imem at
//            consecutive word addresses starting at 0. The CPU is held in
//            stall for the whole load so it only ever fetches a complete
//            image.
//
//            Frame: LEN_LO, LEN_HI (16-bit word count N), then N*BPW payload
//            bytes. With IMEM_LOADER_CHECKSUM_EN defined, one trailer byte
//            follows the payload and must equal the XOR of all payload
//            bytes.
//
// Ports    : clk        in   clock, rising edge
//            rst        in   asynchronous active-high reset
//            start      in   one-cycle pulse, begins a load (IDLE/DONE/ERR)
//            byte_valid in   stream byte valid
//            byte_data  in   stream byte
//            byte_ready out  loader accepts a byte this cycle
//            we         out  imem write strobe, one cycle per word
//            waddr      out  imem word address
//            wdata      out  imem write data
//            cpu_hold   out  high while a load is in progress
//            done       out  last load completed successfully
//            err        out  last load aborted (length or checksum)
//
// Config   : IMEM_LOADER_CHECKSUM_EN - enables the checksum trailer byte
//
// Revision : 1.0  initial release
// ============================================================================

module imem_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int               BPW         = WIDTH / 8;
  localparam int               CNT_W       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [15:0]      C_DEPTH     = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [7:0]       r_len_lo;
  logic [15:0]      r_len;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [15:0]      r_word_cnt;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic [15:0]      w_len_n;
  logic             w_last_word;
  logic             w_accept;
  logic             w_start_ok;
  logic [WIDTH-1:0] w_asm_next;

  // Full length is only meaningful while LEN_HI is on the bus.
  assign w_len_n     = {byte_data, r_len_lo};
  // r_len >= 1 whenever DATA/WRITE are reachable, so N-1 never wraps there.
  assign w_last_word = (r_word_cnt == (r_len - 16'd1));
  assign w_accept    = byte_valid & byte_ready;
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                (r_state == S_ERR));

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < BPW; k++) begin
      if (r_byte_cnt == CNT_W'(k)) begin
        w_asm_next[8*k +: 8] = byte_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    we         = 1'b0;
    cpu_hold   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_next = S_LEN0;
        end
      end
      S_LEN0: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) begin
          w_next = S_LEN1;
        end
      end
      S_LEN1: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) begin
          if (w_len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            // An empty image still carries a trailer (expected 8'h00).
            w_next = S_CSUM;
`else
            w_next = S_DONE;
`endif
          end else if (w_len_n > C_DEPTH) begin
            w_next = S_ERR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && (r_byte_cnt == C_LAST_BYTE)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        we       = 1'b1;
        cpu_hold = 1'b1;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) begin
          w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign done  = (r_state == S_DONE);
  assign err   = (r_state == S_ERR);
  assign waddr = r_word_cnt[ADDR_W-1:0];
  assign wdata = r_wdata;

  // --------------------------------------------------------------------------
  // Datapath: length capture, byte assembly, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_lo   <= 8'd0;
      r_len      <= 16'd0;
      r_byte_cnt <= '0;
      r_word_cnt <= 16'd0;
      r_asm      <= '0;
      r_wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else if (w_start_ok) begin
      r_byte_cnt <= '0;
      r_word_cnt <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_LEN0: begin
          if (w_accept) begin
            r_len_lo <= byte_data;
          end
        end
        S_LEN1: begin
          if (w_accept) begin
            r_len <= w_len_n;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm <= w_asm_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            if (r_byte_cnt == C_LAST_BYTE) begin
              // Output register only changes at word completion, so wdata
              // is stable through WRITE and afterwards.
              r_byte_cnt <= '0;
              r_wdata    <= w_asm_next;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire
